// File: rtl/fpu_pkg.sv
// Shared FP datapath constants and the tag-width helper used by the
// scheduler and its arbiter.
package fpu_pkg;

  localparam int FADD_LAT = 2;
  localparam int FP_W     = 32;

  // Bits needed to index n items; never less than one so a tag always exists.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping mod NREQ.
module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int TW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [TW-1:0]   ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [TW-1:0]   grant_idx,
  output logic            any
);

  always_comb begin : pick
    int idx;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && elig[idx]) begin
        any           = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = TW'(idx);
      end
    end
  end

endmodule

// File: rtl/fadd_sched.sv
// Shares one fixed-latency fadd pipeline among NREQ requesters: round-robin
// issue, per-requester credit limit, and a tag pipe that routes results home.
module fadd_sched
  import fpu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LAT     = FADD_LAT,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [FP_W*NREQ-1:0] req_x1,
  input  logic [FP_W*NREQ-1:0] req_x2,
  output logic [NREQ-1:0]      req_ready,
  output logic [FP_W-1:0]      fa_x1,
  output logic [FP_W-1:0]      fa_x2,
  input  logic [FP_W-1:0]      fa_y,
  output logic [NREQ-1:0]      res_valid,
  output logic [FP_W-1:0]      res_y,
  output logic                 idle,
  output logic [31:0]          issue_cnt
);

  localparam int TW = clog2(NREQ);
  localparam int CW = clog2(MAX_OUT + 1);

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant_oh;
  logic [TW-1:0]   grant_idx;
  logic            issue;

  logic [TW-1:0]   ptr_q, ptr_d;
  logic [LAT-1:0]  vld_q;
  logic [TW-1:0]   tag_q [LAT];
  logic [CW-1:0]   cnt_q [NREQ];
  logic [CW-1:0]   cnt_d [NREQ];
  logic [31:0]     issue_cnt_q, issue_cnt_d;

  logic            ret_v;
  logic [TW-1:0]   ret_tag;
  logic            cnt_zero;

  assign ret_v   = vld_q[LAT-1];
  assign ret_tag = tag_q[LAT-1];

  // A requester holding MAX_OUT credits waits until a result frees one.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] != CW'(MAX_OUT));
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .elig      (elig),
    .ptr       (ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (issue)
  );

  assign req_ready = grant_oh;
  assign fa_x1     = req_x1[int'(grant_idx)*FP_W +: FP_W];
  assign fa_x2     = req_x2[int'(grant_idx)*FP_W +: FP_W];
  assign res_y     = fa_y;
  assign issue_cnt = issue_cnt_q;

  always_comb begin
    ptr_d       = ptr_q;
    issue_cnt_d = issue_cnt_q;
    res_valid   = '0;
    if (issue) begin
      ptr_d       = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + TW'(1);
      issue_cnt_d = issue_cnt_q + 32'd1;
    end
    if (ret_v) begin
      res_valid[ret_tag] = 1'b1;
    end
  end

  // Issue and return to the same requester in one cycle cancel out.
  always_comb begin
    cnt_zero = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((issue && grant_idx == TW'(i)) && !(ret_v && ret_tag == TW'(i))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!(issue && grant_idx == TW'(i)) && (ret_v && ret_tag == TW'(i))) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      if (cnt_q[i] != '0) cnt_zero = 1'b0;
    end
  end

  assign idle = ~|req_valid & ~|vld_q & cnt_zero;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= '0;
      vld_q       <= '0;
      issue_cnt_q <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      issue_cnt_q <= issue_cnt_d;
      vld_q[0]    <= issue;
      for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Tags are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q[0] <= grant_idx;
    for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
  end

endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched with a behavioural 2-cycle fadd; results are routed
// through a queue scoreboard filled at each transfer.
module tb_fadd_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_x1 = '0;
  logic [63:0] req_x2 = '0;
  logic [1:0]  req_ready;
  logic [31:0] fa_x1, fa_x2, fa_y;
  logic [1:0]  res_valid;
  logic [31:0] res_y;
  logic        idle;
  logic [31:0] issue_cnt;

  int checks = 0;
  int errors = 0;
  int res_cnt [2];

  always #5 clk = ~clk;

  fadd_sched #(.NREQ(2), .LAT(2), .MAX_OUT(2)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
    .req_ready(req_ready), .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y),
    .res_valid(res_valid), .res_y(res_y), .idle(idle), .issue_cnt(issue_cnt)
  );

  function automatic real sp2real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) + sp2real(b));
  endfunction

  function automatic logic [31:0] itof(input int n);
    return real2sp(real'(n));
  endfunction

  // Behavioural fadd: issue cycle t -> fa_y valid in cycle t+2.
  logic [31:0] fa_s1, fa_s2;
  always_ff @(posedge clk) begin
    fa_s1 <= fp_add(fa_x1, fa_x2);
    fa_s2 <= fa_s1;
  end
  assign fa_y = fa_s2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] y;
  } sb_t;
  sb_t sbq[$];
  sb_t mon_e;

  always @(negedge clk) begin
    if (rstn) begin
      if (|(req_valid & req_ready)) begin
        mon_e.idx = req_ready[1] ? 1 : 0;
        mon_e.y   = fp_add(req_x1[mon_e.idx*32 +: 32], req_x2[mon_e.idx*32 +: 32]);
        sbq.push_back(mon_e);
      end
      if (|res_valid) begin
        if (sbq.size() == 0) begin
          chk("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("res_owner", 32'(res_valid), 32'(2'b01 << mon_e.idx));
          chk("res_y", res_y, mon_e.y);
          res_cnt[mon_e.idx]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  rdy;
    logic [1:0]  rsv;
    logic [31:0] ry;
    logic        idl;
  } vec_t;
  vec_t vt [11];

  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rdy [7];
    logic [1:0] exp_res [7];
    int n_iss;

    vt[0]  = '{2'b01, F1, F2, 0, 0, 2'b01, 2'b00, 0, 1'b0};
    vt[1]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1'b0};
    vt[2]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 32'h4040_0000, 1'b0};
    vt[3]  = '{2'b10, 0, 0, F1, F1, 2'b10, 2'b00, 0, 1'b0};
    vt[4]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1'b0};
    vt[5]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 32'h4000_0000, 1'b0};
    vt[6]  = '{2'b11, F1, F1, F2, F2, 2'b01, 2'b00, 0, 1'b0};
    vt[7]  = '{2'b10, 0, 0, F2, F2, 2'b10, 2'b00, 0, 1'b0};
    vt[8]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 32'h4000_0000, 1'b0};
    vt[9]  = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 32'h4080_0000, 1'b0};
    vt[10] = '{2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1'b1};

    do_reset();
    @(negedge clk);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_issue_cnt", issue_cnt, 32'd0);
    tick();

    // Single op, a ptr-advancing op, then contention with ptr back at 0.
    for (int i = 0; i < 11; i++) begin
      req_valid = vt[i].rv;
      req_x1    = {vt[i].a1, vt[i].a0};
      req_x2    = {vt[i].b1, vt[i].b0};
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vt[i].rdy));
      chk($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'(vt[i].rsv));
      chk($sformatf("vec%0d_idle", i), 32'(idle), 32'(vt[i].idl));
      if (vt[i].rsv != 2'b00) chk($sformatf("vec%0d_res_y", i), res_y, vt[i].ry);
      tick();
    end

    // Credit limit: req0 alone until four transfers are done.
    exp_rdy = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    exp_res = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
    n_iss = 0;
    for (int c = 0; c < 7; c++) begin
      req_valid = (n_iss < 4) ? 2'b01 : 2'b00;
      req_x1    = {32'd0, itof(c + 1)};
      req_x2    = {32'd0, itof(10)};
      @(negedge clk);
      chk($sformatf("credit%0d_ready", c), 32'(req_ready), 32'(exp_rdy[c]));
      chk($sformatf("credit%0d_res_valid", c), 32'(res_valid), 32'(exp_res[c]));
      if (req_ready[0]) n_iss++;
      tick();
    end
    @(negedge clk);
    chk("credit_idle", 32'(idle), 32'd1);
    tick();

    // Fairness from a fresh reset: strict alternation starting at req0.
    do_reset();
    res_cnt[0] = 0;
    res_cnt[1] = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 2'b11;
      req_x1    = {itof(2 * k + 3), itof(k + 1)};
      req_x2    = {itof(100), itof(7)};
      @(negedge clk);
      chk($sformatf("fair%0d_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    chk("fair_issue_cnt", issue_cnt, 32'd8);
    chk("fair_res0", 32'(res_cnt[0]), 32'd4);
    chk("fair_res1", 32'(res_cnt[1]), 32'd4);

    // Reset while an op is in flight.
    req_valid = 2'b01;
    req_x1    = {32'd0, F1};
    req_x2    = {32'd0, F2};
    tick();
    req_valid = '0;
    rstn      = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid%0d_res_valid", c), 32'(res_valid), 32'd0);
    end
    chk("rstmid_idle", 32'(idle), 32'd1);
    chk("rstmid_issue_cnt", issue_cnt, 32'd0);
    tick();

    // issue_cnt wraps from all-ones to zero.
    force dut.issue_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.issue_cnt_q;
    req_valid = 2'b01;
    req_x1    = {32'd0, F2};
    req_x2    = {32'd0, F2};
    @(negedge clk);
    chk("wrap_pre", issue_cnt, 32'hFFFF_FFFF);
    chk("wrap_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("wrap_post", issue_cnt, 32'd0);
    repeat (3) tick();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
